// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receive path: receiver
//               FSM states, the data byte type and baud timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // One received character
  typedef logic [7:0] data_t;

  // Clocks per serial bit
  function automatic int calc_div(input int freq_hz, input int bps);
    return freq_hz / bps;
  endfunction

  // Clocks from the start edge to the middle of the start bit
  function automatic int calc_half(input int freq_hz, input int bps);
    return calc_div(freq_hz, bps) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with combinational head read. A pop and a
//               push in the same clock are both honoured even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot this clock
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && (!full_o || do_pop);
  end

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; cleared on reset so the head reads zero when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 serial receiver with a small receive FIFO and sticky
//               overrun / framing error flags for the ACIA status register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int clk_freq   = 32000000,
  parameter int baudrate   = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic                        rd,
  input  logic                        clr_err,
  output logic [7:0]                  dout,
  output logic                        rx_avail,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun,
  output logic                        frame_err
);

  localparam int DIV  = calc_div(clk_freq, baudrate);
  localparam int HALF = calc_half(clk_freq, baudrate);
  localparam int CW   = $clog2(DIV + 1);

  logic          rx_meta_q;
  logic          rx_s_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  data_t         shreg_q, shreg_d;
  logic          armed_q, armed_d;
  logic          push;
  logic          stop_low;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overrun_q;
  logic          frame_err_q;

  // Two-flop synchroniser for the asynchronous line; idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state register with its baud counter, bit index and shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic; armed_q keeps a held-low line from re-triggering
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    armed_d = armed_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = CW'(HALF - 1);
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = CW'(DIV - 1);
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = CW'(DIV - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the stop-bit sample pushes the byte and flags a low stop bit
  always_comb begin
    push     = 1'b0;
    stop_low = 1'b0;
    if (state_q == STOP && cnt_q == '0) begin
      push     = 1'b1;
      stop_low = !rx_s_q;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (shreg_q),
    .pop_i   (rd),
    .rdata_o (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Sticky error flags; a new event wins over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= (push && fifo_full && !rd) || (overrun_q && !clr_err);
      frame_err_q <= stop_low || (frame_err_q && !clr_err);
    end
  end

  assign rx_avail  = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
